// File: rtl/src_operand_fetch.sv
// rtl/src_operand_fetch.sv - MSP430 Format-I source-operand fetch sequencer
// Drives SA/As into the register file, walks extension/operand reads, returns one operand per start.
module src_operand_fetch #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [3:0]        src_reg,
  input  logic [1:0]        as_mode,
  input  logic              bw,
  input  logic [DATA_W-1:0] pc_in,
  input  logic [DATA_W-1:0] sout,
  output logic [3:0]        rf_sa,
  output logic [1:0]        rf_as,
  output logic              rf_rw,
  output logic [3:0]        rf_da,
  output logic [DATA_W-1:0] rf_din,
  output logic              pc_inc,
  output logic              mem_req,
  output logic [DATA_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [DATA_W-1:0] operand,
  output logic              done,
  output logic              busy
);

  typedef enum logic [1:0] {S_IDLE, S_EXT, S_RD, S_DONE} state_t;

  state_t            state;
  logic [3:0]        src_q;
  logic [1:0]        as_q;
  logic              bw_q;
  logic              imm_q;
  logic              autoinc_q;
  logic [DATA_W-1:0] addr_q;

  logic              is_const;
  logic              dec_imm;
  logic              dec_autoinc;
  logic              go_ext;
  logic              go_rd;
  logic              launch;
  logic [DATA_W-1:0] rd_val;
  logic [DATA_W-1:0] inc;

  always_comb begin
    is_const    = (src_reg == 4'd3) || ((src_reg == 4'd2) && as_mode[1]);
    dec_imm     = !is_const && (as_mode == 2'b11) && (src_reg == 4'd0);
    dec_autoinc = !is_const && (as_mode == 2'b11) && (src_reg != 4'd0);
    go_ext      = !is_const && (as_mode == 2'b01);
    go_rd       = !is_const && as_mode[1];
  end

  // The register file reads combinationally, so SA/As must point at the new
  // source during the start cycle itself for register/constant operands.
  assign launch = (state == S_IDLE) && start && !rst;
  assign rf_sa  = launch ? src_reg : src_q;
  assign rf_as  = launch ? as_mode : as_q;

  always_comb begin
    rd_val = mem_rdata;
    if (bw_q)
      rd_val = {8'h00, (addr_q[0] ? mem_rdata[15:8] : mem_rdata[7:0])};
    inc = (bw_q && (src_q != 4'd1)) ? 16'd1 : 16'd2;
  end

  assign busy     = (state != S_IDLE);
  assign mem_req  = (state == S_EXT) || (state == S_RD);
  assign mem_addr = (state == S_EXT) ? pc_in :
                    (state == S_RD)  ? addr_q : '0;
  assign pc_inc   = !rst && mem_ack &&
                    ((state == S_EXT) || ((state == S_RD) && imm_q));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      src_q     <= '0;
      as_q      <= '0;
      bw_q      <= 1'b0;
      imm_q     <= 1'b0;
      autoinc_q <= 1'b0;
      addr_q    <= '0;
      operand   <= '0;
      done      <= 1'b0;
      rf_rw     <= 1'b0;
      rf_da     <= '0;
      rf_din    <= '0;
    end else begin
      done   <= 1'b0;
      rf_rw  <= 1'b0;
      rf_da  <= '0;
      rf_din <= '0;
      case (state)
        S_IDLE: begin
          if (start) begin
            src_q     <= src_reg;
            as_q      <= as_mode;
            bw_q      <= bw;
            imm_q     <= dec_imm;
            autoinc_q <= dec_autoinc;
            if (go_ext) begin
              state <= S_EXT;
            end else if (go_rd) begin
              addr_q <= dec_imm ? pc_in : sout;
              state  <= S_RD;
            end else begin
              operand <= bw ? {8'h00, sout[7:0]} : sout;
              done    <= 1'b1;
              state   <= S_DONE;
            end
          end
        end
        S_EXT: begin
          if (mem_ack) begin
            addr_q <= sout + mem_rdata;
            state  <= S_RD;
          end
        end
        S_RD: begin
          if (mem_ack) begin
            operand <= rd_val;
            done    <= 1'b1;
            state   <= S_DONE;
            if (autoinc_q) begin
              rf_rw  <= 1'b1;
              rf_da  <= src_q;
              rf_din <= addr_q + inc;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_src_operand_fetch.sv
// tb/tb_src_operand_fetch.sv - directed self-checking bench for src_operand_fetch
// Models the register file (with constant generator) and a wait-stated memory.
module tb_src_operand_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  src_reg = '0;
  logic [1:0]  as_mode = '0;
  logic        bw = 1'b0;
  logic [15:0] pc_in = '0;
  logic [15:0] sout;
  logic [3:0]  rf_sa;
  logic [1:0]  rf_as;
  logic        rf_rw;
  logic [3:0]  rf_da;
  logic [15:0] rf_din;
  logic        pc_inc;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic [15:0] mem_rdata;
  logic        mem_ack;
  logic [15:0] operand;
  logic        done;
  logic        busy;

  src_operand_fetch #(.DATA_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .src_reg(src_reg), .as_mode(as_mode),
    .bw(bw), .pc_in(pc_in), .sout(sout), .rf_sa(rf_sa), .rf_as(rf_as),
    .rf_rw(rf_rw), .rf_da(rf_da), .rf_din(rf_din), .pc_inc(pc_inc),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .operand(operand), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  logic [15:0] regs [16];
  always_comb begin
    sout = regs[rf_sa];
    if (rf_sa == 4'd0) sout = pc_in;
    if (rf_sa == 4'd2) begin
      case (rf_as)
        2'b01:   sout = 16'h0000;
        2'b10:   sout = 16'h0004;
        2'b11:   sout = 16'h0008;
        default: sout = regs[2];
      endcase
    end
    if (rf_sa == 4'd3) begin
      case (rf_as)
        2'b00:   sout = 16'h0000;
        2'b01:   sout = 16'h0001;
        2'b10:   sout = 16'h0002;
        default: sout = 16'hFFFF;
      endcase
    end
  end

  logic [15:0] w0_addr = '0, w0_data = '0, w1_addr = '1, w1_data = '0;
  int          waits = 0;
  int          wcnt = 0;
  assign mem_rdata = (mem_addr == w0_addr) ? w0_data :
                     (mem_addr == w1_addr) ? w1_data : 16'h0000;
  assign mem_ack   = mem_req && (wcnt == waits);
  always @(posedge clk) wcnt <= (mem_req && !mem_ack) ? wcnt + 1 : 0;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  int          r_lat, r_nreq, r_npc, r_pccyc, r_nrw, r_extra;
  logic [15:0] r_op, r_first, r_last, r_rdin;
  logic [3:0]  r_rda;
  int          n_overlap = 0, n_addr_idle = 0;

  always @(negedge clk) begin
    if (pc_inc && rf_rw) n_overlap++;
    if (!mem_req && mem_addr != 16'h0000) n_addr_idle++;
  end

  task automatic do_fetch(input logic [3:0] s, input logic [1:0] a, input logic b, input int rcyc);
    int cyc;
    r_lat = -1; r_nreq = 0; r_npc = 0; r_pccyc = -1; r_nrw = 0; r_extra = 0;
    r_op = '0; r_first = '0; r_last = '0; r_rdin = '0; r_rda = '0;
    @(negedge clk);
    src_reg = s; as_mode = a; bw = b; start = 1'b1;
    for (cyc = 1; cyc <= 30; cyc++) begin
      @(negedge clk);
      start = (cyc == rcyc);
      if (start) src_reg = 4'd9;
      if (mem_req) begin
        if (r_nreq == 0) r_first = mem_addr;
        r_last = mem_addr;
        r_nreq++;
      end
      if (pc_inc) begin
        r_npc++;
        if (r_pccyc < 0) r_pccyc = cyc;
      end
      if (rf_rw) begin
        r_nrw++;
        r_rda = rf_da;
        r_rdin = rf_din;
      end
      if (done) begin
        r_lat = cyc;
        r_op = operand;
        break;
      end
    end
    start = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done || busy || rf_rw || pc_inc) r_extra++;
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) regs[i] = 16'h1000 + 16'(i);
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_operand", operand, 0);
    chk("rst_rf_sa", rf_sa, 0);
    chk("rst_rf_as", rf_as, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_done_rw_pc", {done, rf_rw, pc_inc}, 0);
    rst = 1'b0;

    regs[5] = 16'h1234;
    do_fetch(4'd5, 2'b00, 1'b0, 0);
    chk("reg_lat", r_lat, 1);
    chk("reg_op", r_op, 16'h1234);
    chk("reg_noacc", r_nreq + r_nrw, 0);
    do_fetch(4'd5, 2'b00, 1'b1, 0);
    chk("reg_byte_op", r_op, 16'h0034);

    do_fetch(4'd3, 2'b11, 1'b0, 0);
    chk("cg3_lat", r_lat, 1);
    chk("cg3_op", r_op, 16'hFFFF);
    chk("cg3_noacc", r_nreq, 0);
    do_fetch(4'd2, 2'b10, 1'b0, 0);
    chk("cg2_op", r_op, 16'h0004);
    chk("cg2_noacc", r_nreq, 0);

    regs[4] = 16'h0200; pc_in = 16'hC010; waits = 1;
    w0_addr = 16'hC010; w0_data = 16'h0010; w1_addr = 16'h0210; w1_data = 16'hBEEF;
    do_fetch(4'd4, 2'b01, 1'b0, 0);
    chk("idx_first_addr", r_first, 16'hC010);
    chk("idx_last_addr", r_last, 16'h0210);
    chk("idx_npc", r_npc, 1);
    chk("idx_pc_cyc", r_pccyc, 2);
    chk("idx_op", r_op, 16'hBEEF);
    chk("idx_lat", r_lat, 5);
    chk("idx_nrw", r_nrw, 0);

    waits = 0; regs[6] = 16'h0301; w0_addr = 16'h0301; w0_data = 16'hAB12;
    do_fetch(4'd6, 2'b11, 1'b1, 0);
    chk("ai6_addr", r_first, 16'h0301);
    chk("ai6_op", r_op, 16'h00AB);
    chk("ai6_lat", r_lat, 2);
    chk("ai6_nrw", r_nrw, 1);
    chk("ai6_rda", r_rda, 4'd6);
    chk("ai6_rdin", r_rdin, 16'h0302);

    regs[1] = 16'h0300; w0_addr = 16'h0300; w0_data = 16'h5678;
    do_fetch(4'd1, 2'b11, 1'b1, 0);
    chk("ai1_op", r_op, 16'h0078);
    chk("ai1_rda", r_rda, 4'd1);
    chk("ai1_rdin", r_rdin, 16'h0302);

    regs[7] = 16'hFFFF; w0_addr = 16'hFFFF; w0_data = 16'h1357;
    do_fetch(4'd7, 2'b11, 1'b0, 0);
    chk("ai7_wrap_rdin", r_rdin, 16'h0001);
    chk("ai7_op", r_op, 16'h1357);

    pc_in = 16'hC020; w0_addr = 16'hC020; w0_data = 16'h5A5A;
    do_fetch(4'd0, 2'b11, 1'b0, 0);
    chk("imm_addr", r_first, 16'hC020);
    chk("imm_npc", r_npc, 1);
    chk("imm_pc_cyc", r_pccyc, 1);
    chk("imm_op", r_op, 16'h5A5A);
    chk("imm_nrw", r_nrw, 0);
    chk("imm_lat", r_lat, 2);

    waits = 1; w0_addr = 16'h1234; w0_data = 16'h4321;
    do_fetch(4'd5, 2'b10, 1'b0, 1);
    chk("ind_busy_start_lat", r_lat, 3);
    chk("ind_op", r_op, 16'h4321);
    chk("ind_nrw", r_nrw, 0);
    chk("ind_no_second_done", r_extra, 0);

    waits = 2; pc_in = 16'hC030; w0_addr = 16'hC030; w0_data = 16'h1111;
    @(negedge clk);
    src_reg = 4'd0; as_mode = 2'b11; bw = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rstmid_ack", {mem_req, mem_ack}, 2'b11);
    chk("rstmid_no_pcinc", pc_inc, 0);
    @(negedge clk);
    rst = 1'b0;
    chk("rstmid_busy", busy, 0);
    chk("rstmid_mem_req", mem_req, 0);
    chk("rstmid_operand", operand, 0);
    chk("rstmid_done_rw", {done, rf_rw}, 0);
    repeat (3) begin
      @(negedge clk);
      chk("rstmid_quiet", {done, rf_rw, pc_inc, busy}, 0);
    end

    chk("no_pcinc_rw_overlap", n_overlap, 0);
    chk("addr_zero_when_idle", n_addr_idle, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
